// File: rtl/rv32i_multiplier_arbiter_pkg.sv
// Shared state encoding and parameter defaults for the multiplier arbiter.
package rv32i_multiplier_arbiter_pkg;

   typedef enum logic [1:0] {
      ArbIdle,
      ArbBusy,
      ArbResp
   } arb_state_e;

   localparam int unsigned OpwDefault           = 16;
   localparam int unsigned ReswDefault          = 32;
   localparam int unsigned TimeoutCyclesDefault = 64;

endpackage

// File: rtl/rv32i_rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module rv32i_rr_priority_picker
   import rv32i_multiplier_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDXW    = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDXW-1:0]    i_ptr,
   output logic               o_valid,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [IDXW-1:0]    o_idx
);

   logic            hi_found;
   logic            lo_found;
   logic [IDXW-1:0] hi_idx;
   logic [IDXW-1:0] lo_idx;

   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      // Downward scan leaves the lowest hit; hi_* only sees slots at or above the pointer.
      for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
         if (i_req[j]) begin
            lo_found = 1'b1;
            lo_idx   = IDXW'(j);
            if (IDXW'(j) >= i_ptr) begin
               hi_found = 1'b1;
               hi_idx   = IDXW'(j);
            end
         end
      end
   end

   assign o_valid  = lo_found;
   assign o_idx    = hi_found ? hi_idx : lo_idx;
   assign o_onehot = lo_found ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/rv32i_multiplier_arbiter.sv
// Round-robin arbiter sharing one multiplier IP between NUM_REQ requesters.
// Define MULTIPLIER_ARBITER_TIMEOUT_EN to add a watchdog and the o_rsp_error output.
module rv32i_multiplier_arbiter
   import rv32i_multiplier_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
   parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault,
`endif
   parameter int unsigned OPW            = OpwDefault,
   parameter int unsigned RESW           = ReswDefault
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
   output logic                   o_rsp_error,
`endif
   input  logic [NUM_REQ-1:0]     i_req_en,
   input  logic [NUM_REQ*OPW-1:0] i_req_operand_one,
   input  logic [NUM_REQ*OPW-1:0] i_req_operand_two,
   output logic [NUM_REQ-1:0]     o_rsp_valid,
   output logic [RESW-1:0]        o_rsp_result,
   output logic [NUM_REQ-1:0]     o_grant,
   output logic                   o_busy,
   output logic                   o_multiplier_en,
   output logic [OPW-1:0]         o_multiplier_operand_one,
   output logic [OPW-1:0]         o_multiplier_operand_two,
   input  logic                   i_multiplier_valid,
   input  logic [RESW-1:0]        i_multiplier_result
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e        state_q, state_d;
   logic [IdxW-1:0]   ptr_q, ptr_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic              busy_q, busy_d;
   logic              mul_en_q, mul_en_d;
   logic [OPW-1:0]    op_a_q, op_a_d;
   logic [OPW-1:0]    op_b_q, op_b_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [RESW-1:0]   result_q, result_d;
   logic              done;

`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
   localparam int unsigned WdogW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WdogW-1:0]  wdog_q, wdog_d;
   logic              error_q, error_d;
`endif

   logic               win_valid;
   logic [NUM_REQ-1:0] win_onehot;
   logic [IdxW-1:0]    win_idx;

   rv32i_rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDXW    (IdxW)
   ) u_picker (
      .i_req    (i_req_en),
      .i_ptr    (ptr_q),
      .o_valid  (win_valid),
      .o_onehot (win_onehot),
      .o_idx    (win_idx)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      idx_d       = idx_q;
      grant_d     = grant_q;
      busy_d      = busy_q;
      mul_en_d    = mul_en_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      rsp_valid_d = rsp_valid_q;
      result_d    = result_q;
      done        = 1'b0;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
      wdog_d      = wdog_q;
      error_d     = error_q;
`endif
      unique case (state_q)
         ArbIdle: begin
            if (win_valid) begin
               op_a_d   = i_req_operand_one[win_idx*OPW +: OPW];
               op_b_d   = i_req_operand_two[win_idx*OPW +: OPW];
               idx_d    = win_idx;
               grant_d  = win_onehot;
               busy_d   = 1'b1;
               mul_en_d = 1'b1;
               state_d  = ArbBusy;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
               wdog_d   = '0;
`endif
            end
         end
         ArbBusy: begin
            done = i_multiplier_valid;
            if (i_multiplier_valid) begin
               result_d = i_multiplier_result;
            end
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
            else if (wdog_q == WdogW'(TIMEOUT_CYCLES - 1)) begin
               done     = 1'b1;
               result_d = '0;
               error_d  = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
`endif
            if (done) begin
               mul_en_d    = 1'b0;
               rsp_valid_d = grant_q;
               ptr_d       = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
               state_d     = ArbResp;
            end
         end
         ArbResp: begin
            // Winner's request is still high here; it is deliberately not looked at.
            rsp_valid_d = '0;
            grant_d     = '0;
            busy_d      = 1'b0;
            state_d     = ArbIdle;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
            error_d     = 1'b0;
`endif
         end
         default: state_d = ArbIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ArbIdle;
         ptr_q       <= '0;
         idx_q       <= '0;
         grant_q     <= '0;
         busy_q      <= 1'b0;
         mul_en_q    <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rsp_valid_q <= '0;
         result_q    <= '0;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
         wdog_q      <= '0;
         error_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         idx_q       <= idx_d;
         grant_q     <= grant_d;
         busy_q      <= busy_d;
         mul_en_q    <= mul_en_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         rsp_valid_q <= rsp_valid_d;
         result_q    <= result_d;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
         wdog_q      <= wdog_d;
         error_q     <= error_d;
`endif
      end
   end

   assign o_rsp_valid              = rsp_valid_q;
   assign o_rsp_result             = result_q;
   assign o_grant                  = grant_q;
   assign o_busy                   = busy_q;
   assign o_multiplier_en          = mul_en_q;
   assign o_multiplier_operand_one = op_a_q;
   assign o_multiplier_operand_two = op_b_q;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
   assign o_rsp_error              = error_q;
`endif

endmodule

// File: tb/tb_rv32i_multiplier_arbiter.sv
// Bench for rv32i_multiplier_arbiter: directed vectors, corner sequences and a random run
// checked every cycle against a transaction-level reference model.
module tb_rv32i_multiplier_arbiter;

   localparam int unsigned N  = 2;
   localparam int unsigned W  = 16;
   localparam int unsigned RW = 32;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
   localparam int TO    = 8;
`else
   localparam bit TO_EN = 1'b0;
   localparam int TO    = 0;
`endif

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_en;
   logic [W-1:0]    opa [N];
   logic [W-1:0]    opb [N];
   logic [N*W-1:0]  opa_p, opb_p;
   logic [N-1:0]    rsp_valid;
   logic [RW-1:0]   rsp_result;
   logic [N-1:0]    grant;
   logic            busy;
   logic            mul_en;
   logic [W-1:0]    mul_op1, mul_op2;
   logic            ipv;
   logic [RW-1:0]   ipr;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
   logic            rsp_err;
`endif

   always_comb begin
      for (int k = 0; k < int'(N); k++) begin
         opa_p[k*W +: W] = opa[k];
         opb_p[k*W +: W] = opb[k];
      end
   end

   rv32i_multiplier_arbiter #(
      .NUM_REQ        (N),
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
      .TIMEOUT_CYCLES (TO),
`endif
      .OPW            (W),
      .RESW           (RW)
   ) u_dut (
      .i_clk                    (clk),
      .i_rst_n                  (rst_n),
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
      .o_rsp_error              (rsp_err),
`endif
      .i_req_en                 (req_en),
      .i_req_operand_one        (opa_p),
      .i_req_operand_two        (opb_p),
      .o_rsp_valid              (rsp_valid),
      .o_rsp_result             (rsp_result),
      .o_grant                  (grant),
      .o_busy                   (busy),
      .o_multiplier_en          (mul_en),
      .o_multiplier_operand_one (mul_op1),
      .o_multiplier_operand_two (mul_op2),
      .i_multiplier_valid       (ipv),
      .i_multiplier_result      (ipr)
   );

   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // Reference model: phase 0 idle, 1 multiplying, 2 responding.
   int          ph, cur, ptr_m, wd;
   logic [W-1:0] la, lb;
   logic [RW-1:0] mres;
   bit          merr;

   int ip_lat, ip_cnt;
   bit ip_on, hold_mode, rand_mode;

   typedef struct {
      int           req;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           lat;
      logic [RW-1:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      ph = 0; cur = 0; ptr_m = 0; wd = 0;
      la = '0; lb = '0; mres = '0; merr = 1'b0;
   endtask

   task automatic model_step();
      bit found;
      case (ph)
         0: begin
            found = 1'b0;
            for (int i = 0; i < int'(N); i++) begin
               int k;
               k = (ptr_m + i) % int'(N);
               if (!found && req_en[k]) begin
                  found = 1'b1;
                  cur   = k;
               end
            end
            if (found) begin
               la = opa[cur]; lb = opb[cur]; wd = 0; ph = 1;
            end
         end
         1: begin
            if (ipv) begin
               mres = ipr; merr = 1'b0; ph = 2; ptr_m = (cur + 1) % int'(N);
            end else if (TO_EN && wd == TO - 1) begin
               mres = '0; merr = 1'b1; ph = 2; ptr_m = (cur + 1) % int'(N);
            end else begin
               wd++;
            end
         end
         default: begin
            ph = 0; merr = 1'b0;
         end
      endcase
   endtask

   task automatic compare_outputs();
      logic [N-1:0] eg, ev;
      eg = (ph != 0) ? (N'(1) << cur) : '0;
      ev = (ph == 2) ? (N'(1) << cur) : '0;
      check("grant", 32'(grant), 32'(eg));
      check("busy", 32'(busy), 32'(ph != 0));
      check("mul_en", 32'(mul_en), 32'(ph == 1));
      check("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ph == 1) begin
         check("ip_op_one", 32'(mul_op1), 32'(la));
         check("ip_op_two", 32'(mul_op2), 32'(lb));
      end
      if (ph == 2) begin
         check("rsp_result", rsp_result, mres);
         if (!merr) check("rsp_product", rsp_result, 32'(la) * 32'(lb));
      end
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
      check("rsp_error", 32'(rsp_err), 32'(merr));
`endif
   endtask

   // One clock: advance model, compare, then play the IP and the requesters.
   task automatic cycle();
      @(negedge clk);
      if (!rst_n) model_reset();
      else model_step();
      compare_outputs();
      if (ip_on && mul_en && !ipv) begin
         ip_cnt++;
         if (ip_cnt >= ip_lat) begin
            ipv = 1'b1;
            ipr = 32'(mul_op1) * 32'(mul_op2);
         end
      end else begin
         ipv    = 1'b0;
         ip_cnt = 0;
         ipr    = $urandom();
      end
      for (int k = 0; k < int'(N); k++) begin
         if (rsp_valid[k] && !hold_mode) req_en[k] = 1'b0;
         if (rand_mode && !req_en[k] && !rsp_valid[k] && $urandom_range(0, 3) == 0) begin
            req_en[k] = 1'b1;
            opa[k]    = 16'($urandom());
            opb[k]    = 16'($urandom());
         end
      end
      if (rand_mode && ph == 1 && $urandom_range(0, 7) == 0) opa[cur] = 16'($urandom());
      if (rand_mode && !mul_en) ip_lat = $urandom_range(1, 5);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   task automatic run_single(input vec_t t);
      int en_cnt, rv_cnt;
      bit other;
      logic [RW-1:0] got;
      en_cnt = 0; rv_cnt = 0; other = 1'b0; got = '0;
      ip_lat = t.lat; opa[t.req] = t.a; opb[t.req] = t.b; req_en[t.req] = 1'b1;
      for (int c = 0; c < t.lat + 6; c++) begin
         cycle();
         if (mul_en) en_cnt++;
         if (rsp_valid[t.req]) begin
            rv_cnt++;
            got = rsp_result;
         end
         if ((rsp_valid & ~(N'(1) << t.req)) != '0) other = 1'b1;
      end
      check($sformatf("vec_req%0d_en_cycles", t.req), en_cnt, t.lat);
      check($sformatf("vec_req%0d_rsp_count", t.req), rv_cnt, 1);
      check($sformatf("vec_req%0d_result", t.req), got, t.exp);
      check($sformatf("vec_req%0d_other_rsp", t.req), 32'(other), 0);
   endtask

   vec_t vecs [5];

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int seq [$];
      int order [$];
      bit prev, onehot_ok;
      int cnt;
      logic [RW-1:0] r;

      clk = 1'b0; rst_n = 1'b0; req_en = '0; ipv = 1'b0; ipr = '0;
      for (int k = 0; k < int'(N); k++) begin
         opa[k] = '0; opb[k] = '0;
      end
      ip_lat = 3; ip_cnt = 0; ip_on = 1'b1; hold_mode = 1'b0; rand_mode = 1'b0;
      n_checks = 0; n_fail = 0;
      model_reset();

      vecs[0] = '{0, 16'h0003, 16'h0005, 3, 32'h0000000F};
      vecs[1] = '{1, 16'hFFFF, 16'hFFFF, 1, 32'hFFFE0001};
      vecs[2] = '{0, 16'h0000, 16'h1234, 2, 32'h00000000};
      vecs[3] = '{1, 16'h0100, 16'h0100, 5, 32'h00010000};
      vecs[4] = '{0, 16'h8000, 16'h0002, 4, 32'h00010000};

      repeat (3) cycle();
      check("reset_grant", 32'(grant), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_mul_en", 32'(mul_en), 0);
      check("reset_rsp_valid", 32'(rsp_valid), 0);
      check("reset_rsp_result", rsp_result, 0);
      check("reset_op_one", 32'(mul_op1), 0);
      check("reset_op_two", 32'(mul_op2), 0);
      rst_n = 1'b1;

      for (int v = 0; v < 5; v++) run_single(vecs[v]);

      // Simultaneous requests straight out of reset.
      do_reset();
      opa[0] = 16'd2; opb[0] = 16'd3; opa[1] = 16'd7; opb[1] = 16'd4;
      ip_lat = 2; req_en = 2'b11;
      prev = 1'b0; onehot_ok = 1'b1;
      repeat (16) begin
         cycle();
         if (mul_en && !prev) seq.push_back(int'(mul_op1));
         prev = mul_en;
         if ($countones(grant) > 1) onehot_ok = 1'b0;
      end
      check("simul_txn_count", seq.size(), 2);
      check("simul_first_op", (seq.size() > 0) ? seq[0] : -1, 2);
      check("simul_second_op", (seq.size() > 1) ? seq[1] : -1, 7);
      check("simul_onehot", 32'(onehot_ok), 1);

      // Continuous contention: both requests held high throughout.
      do_reset();
      hold_mode = 1'b1; ip_lat = 1; req_en = 2'b11; prev = 1'b0;
      for (int c = 0; c < 60 && order.size() < 6; c++) begin
         cycle();
         if (busy && !prev) order.push_back(grant[1] ? 1 : 0);
         prev = busy;
      end
      check("rr_txn_count", order.size(), 6);
      for (int i = 0; i < order.size() && i < 6; i++) check($sformatf("rr_order%0d", i), order[i], i % 2);
      req_en = '0; hold_mode = 1'b0;
      repeat (8) cycle();

      // Winner changes its operands while the multiply is in flight.
      opa[0] = 16'd3; opb[0] = 16'd5; ip_lat = 4; req_en[0] = 1'b1;
      cycle(); cycle();
      opa[0] = 16'h00AA; opb[0] = 16'h0055;
      cycle();
      check("stable_op_one", 32'(mul_op1), 3);
      check("stable_op_two", 32'(mul_op2), 5);
      r = '1;
      repeat (8) begin
         cycle();
         if (rsp_valid[0]) r = rsp_result;
      end
      check("stable_result", r, 32'h0000000F);

      // Stray IP valid while idle must be ignored.
      ipv = 1'b1; ipr = 32'hDEADBEEF;
      cycle();
      check("stray_valid_busy", 32'(busy), 0);
      check("stray_valid_rsp", 32'(rsp_valid), 0);
      cycle();

      // Requester drops its request mid-transaction; result is still strobed.
      opa[1] = 16'd6; opb[1] = 16'd7; ip_lat = 3; req_en[1] = 1'b1;
      cycle();
      req_en[1] = 1'b0;
      cnt = 0; r = '0;
      repeat (8) begin
         cycle();
         if (rsp_valid[1]) begin
            cnt++;
            r = rsp_result;
         end
      end
      check("drop_rsp_count", cnt, 1);
      check("drop_result", r, 42);

      // Asynchronous reset two cycles into a transaction.
      do_reset();
      opa[0] = 16'd5; opb[0] = 16'd5; opa[1] = 16'd9; opb[1] = 16'd9;
      ip_lat = 10; req_en = 2'b11;
      cycle();
      check("rst_mid_first_grant", 32'(grant), 32'b01);
      cycle();
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_mul_en", 32'(mul_en), 0);
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_grant", 32'(grant), 0);
      model_reset();
      req_en[0] = 1'b0;
      cycle(); cycle();
      rst_n = 1'b1; ip_lat = 2;
      cycle();
      check("rst_post_grant", 32'(grant), 32'b10);
      cnt = 0; r = '0;
      repeat (10) begin
         cycle();
         if (rsp_valid[1]) begin
            cnt++;
            r = rsp_result;
         end
         if (rsp_valid[0]) cnt = cnt + 100;
      end
      check("rst_post_rsp_count", cnt, 1);
      check("rst_post_result", r, 81);

`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
      begin : timeout_seq
         int en_cnt;
         bit seen, e;
         ip_on = 1'b0; opa[0] = 16'h0011; opb[0] = 16'h0022; req_en[0] = 1'b1;
         en_cnt = 0; seen = 1'b0; e = 1'b0; r = '1;
         for (int c = 0; c < 20; c++) begin
            cycle();
            if (mul_en) en_cnt++;
            if (rsp_valid[0]) begin
               seen = 1'b1;
               r    = rsp_result;
               e    = rsp_err;
            end
         end
         check("to_busy_cycles", en_cnt, TO);
         check("to_rsp_seen", 32'(seen), 1);
         check("to_error_with_valid", 32'(e), 1);
         check("to_result_zero", r, 0);
         ipv = 1'b1; ipr = 32'h12345678;
         cycle();
         check("to_late_valid_busy", 32'(busy), 0);
         ip_on = 1'b1;
         run_single('{1, 16'h0004, 16'h0004, 2, 32'h00000010});
      end
`endif

      // Random traffic against the model.
      rand_mode = 1'b1;
      repeat (400) cycle();
      rand_mode = 1'b0;
      repeat (60) cycle();
      check("drain_idle", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rv32i_multiplier_arbiter.md
Name: rv32I_multiplier_arbiter

Overview:
- Shares the single 16x16 multiplier IP between NUM_REQ requesters, e.g. the shift controlpath and the M-extension multiply sequencer.
- Each requester sees a private en/valid handshake identical to the multiplier IP's own handshake.
- The arbiter issues one transaction at a time to the IP and routes the result back to the winner.
- Arbitration is round-robin between transactions.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- OPW, 16, operand width of the multiplier IP.
- RESW, 32, result width of the multiplier IP.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- i_clk  in  1  core clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_en  in  NUM_REQ  per-requester request; held high with stable operands until its o_rsp_valid bit is seen.
- i_req_operand_one  in  NUM_REQ*OPW  packed operand A; requester k uses slice [k*OPW +: OPW].
- i_req_operand_two  in  NUM_REQ*OPW  packed operand B.
- o_rsp_valid  out  NUM_REQ  one-cycle result strobe to the granted requester.
- o_rsp_result  out  RESW  shared result bus; meaningful only while some o_rsp_valid bit is high.
- o_grant  out  NUM_REQ  one-hot current owner; zero when idle.
- o_busy  out  1  transaction in flight.
- o_multiplier_en  out  1  enable to the multiplier IP.
- o_multiplier_operand_one  out  OPW  operand A to the IP.
- o_multiplier_operand_two  out  OPW  operand B to the IP.
- i_multiplier_valid  in  1  IP result valid.
- i_multiplier_result  in  RESW  IP product.

Behaviour:
- Reset values: every output is 0; round-robin pointer is 0; state is ArbIdle. Reset is asynchronous assert, synchronous deassert.
- States and transitions:
  - ArbIdle: if any i_req_en bit is high, pick the winner by round-robin. Search starts at the pointer and wraps modulo NUM_REQ.
  - ArbIdle, on the winning edge: latch the winner's operands into the IP operand registers, set o_grant, o_busy and o_multiplier_en, then go to ArbBusy.
  - ArbBusy: hold o_multiplier_en and the operands stable. On the edge where i_multiplier_valid=1:
    - clear o_multiplier_en;
    - register i_multiplier_result into o_rsp_result;
    - set o_rsp_valid[grant];
    - set pointer = grant index + 1, with wrap;
    - go to ArbResp.
  - ArbResp: o_rsp_valid is high for exactly this cycle. The winner's i_req_en is still high here and must be ignored. On the next edge clear o_rsp_valid, o_grant and o_busy, and return to ArbIdle.
- Requesters must drop i_req_en on the edge where they sample o_rsp_valid. A request still high in ArbIdle is treated as a new transaction.
- Latency: the request is sampled at edge E0 and IP en is high after E0. IP valid is sampled at E1 and rsp_valid is high after E1. Minimum turnaround is one IP latency plus 2 cycles of idle and resp overhead.
- Simultaneous requests: exactly one grant per transaction. Losers stay pending, with no loss and no reorder of their operands.
- Operand changes by the winner during ArbBusy have no effect, because operands are latched.
- i_multiplier_valid outside ArbBusy is ignored.
- An i_req_en bit dropping mid-transaction does not abort the transaction. The result is still strobed and may be ignored by the requester.
- Reset mid-transaction: o_multiplier_en drops immediately and asynchronously. The in-flight result is discarded and the pointer returns to 0. Requesters that still hold i_req_en are re-arbitrated after reset release.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0.

Optional Feature:
- Macro: MULTIPLIER_ARBITER_TIMEOUT_EN.
- Defined:
  - adds output o_rsp_error (1 bit, resets to 0) and a watchdog counter, cleared on entry to ArbBusy;
  - if TIMEOUT_CYCLES cycles elapse in ArbBusy without i_multiplier_valid, clear o_multiplier_en, drive o_rsp_result=0, and pulse o_rsp_valid[grant] and o_rsp_error together;
  - the transition is to ArbResp and the pointer advances normally;
  - a late i_multiplier_valid after this is ignored.
- Undefined: no counter and no port; ArbBusy waits indefinitely.

Decomposition:
- Package rv32I_multiplier_arbiter_pkg holds:
  - the arb_state_e enum (ArbIdle, ArbBusy, ArbResp);
  - OPW and RESW default localparams;
  - the default TIMEOUT_CYCLES.
- Sub-module rv32I_rr_priority_picker:
  - purely combinational;
  - inputs: request vector and pointer;
  - outputs: one-hot winner and index.

Test Plan:
- Single requester: req0 with A=16'h0003, B=16'h0005, IP returns 32'h0000000F after 3 cycles. Expected: o_grant=01, o_multiplier_en high 3 cycles, o_rsp_valid=01 for exactly one cycle, o_rsp_result=32'h0000000F, o_rsp_valid[1] never set.
- Simultaneous requests from reset: req0 and req1 both asserted (A0=2, A1=7). Expected: req0 is served first, then req1; IP operand_one sequence is 2 then 7; o_grant is one-hot throughout.
- Continuous contention: both requesters hold requests for 6 transactions. Expected: grant order 0,1,0,1,0,1; no back-to-back grants to the same requester while the other is pending.
- Operand stability: the winner changes operands during ArbBusy. Expected: IP operands unchanged; result corresponds to the latched values.
- Reset mid-ArbBusy: assert i_rst_n=0 two cycles into a transaction. Expected: o_multiplier_en and o_busy go low asynchronously and no o_rsp_valid is produced. After release, the still-pending req1 is granted first (pointer=0, req0 idle).
- Timeout, with the macro defined and TIMEOUT_CYCLES=8: the IP never asserts valid. Expected: after 8 ArbBusy cycles, o_rsp_valid and o_rsp_error pulse together, o_rsp_result=0, and the next request is granted normally.
